// File: rtl/io_reg_scheduler.sv
// IO register file shared by the Core write port and a serial host, with a round-robin
// scheduler that streams CPU-updated registers to the transmitter. Optional: IO_SCHED_WATCHDOG_EN.
module io_reg_scheduler #(
    parameter int NUM_REGS   = 32,
    parameter int MAX_WAIT   = 7,
    parameter int TX_TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  cpu_rd_sel,
    output logic [14:0] cpu_rd_data,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_wr_sel,
    input  logic [14:0] cpu_wr_data,
    output logic        cpu_stall,
    input  logic        host_valid,
    input  logic [4:0]  host_sel,
    input  logic [14:0] host_data,
    output logic        host_ready,
    output logic        tx_valid,
    output logic [4:0]  tx_sel,
    output logic [14:0] tx_data,
    input  logic        tx_ready,
    output logic [14:0] verb_data,
    output logic        tx_timeout
);

    localparam int DEPTH  = 32;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    state_e              state_q, state_d;
    logic [14:0]         regs_q [DEPTH];
    logic [14:0]         regs_d [DEPTH];
    logic [DEPTH-1:0]    dirty_q, dirty_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [4:0]          rr_q, rr_d;
    logic                tx_valid_q, tx_valid_d;
    logic [4:0]          tx_sel_q, tx_sel_d;
    logic [14:0]         tx_data_q, tx_data_d;

    logic        starve, host_wr, cpu_wr, cpu_in, host_in, rd_in;
    logic        found;
    logic [4:0]  pick;
    logic [5:0]  cand;

`ifdef IO_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TX_TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // Only one of host_wr / cpu_wr can be true in a cycle, so the regfile has a single write port.
    assign starve     = (wait_q == WAIT_W'(MAX_WAIT));
    assign host_ready = !cpu_we || starve;
    assign cpu_stall  = cpu_we && starve && host_valid;
    assign host_wr    = host_valid && host_ready;
    assign cpu_wr     = cpu_we && !cpu_stall;
    assign cpu_in     = int'(cpu_wr_sel) < NUM_REGS;
    assign host_in    = int'(host_sel) < NUM_REGS;
    assign rd_in      = int'(cpu_rd_sel) < NUM_REGS;

    assign cpu_rd_data = rd_in ? regs_q[cpu_rd_sel] : 15'd0;
    assign verb_data   = regs_q[0];
    assign tx_valid    = tx_valid_q;
    assign tx_sel      = tx_sel_q;
    assign tx_data     = tx_data_q;

    always_comb begin
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        wait_d     = '0;
        state_d    = state_q;
        rr_d       = rr_q;
        tx_valid_d = tx_valid_q;
        tx_sel_d   = tx_sel_q;
        tx_data_d  = tx_data_q;
        found      = 1'b0;
        pick       = '0;
        cand       = '0;
`ifdef IO_SCHED_WATCHDOG_EN
        wd_d       = '0;
        timeout_d  = 1'b0;
`endif

        if (host_valid && !host_ready)
            wait_d = starve ? wait_q : wait_q + WAIT_W'(1);

        // First dirty index at or above rr_q, wrapping at NUM_REGS.
        for (int i = 0; i < NUM_REGS; i++) begin
            cand = {1'b0, rr_q} + 6'(i);
            if (int'(cand) >= NUM_REGS)
                cand = cand - 6'(NUM_REGS);
            if (!found && dirty_q[cand[4:0]]) begin
                found = 1'b1;
                pick  = cand[4:0];
            end
        end

        // tx handshake: a frame is transferred on a cycle with tx_valid && tx_ready; while
        // tx_valid is high, tx_sel/tx_data never change.
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    tx_sel_d      = pick;
                    tx_data_d     = regs_q[pick];
                    tx_valid_d    = 1'b1;
                    dirty_d[pick] = 1'b0;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    rr_d       = (int'(tx_sel_q) == NUM_REGS - 1) ? 5'd0 : tx_sel_q + 5'd1;
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
`ifdef IO_SCHED_WATCHDOG_EN
                else if (wd_q == WD_W'(TX_TIMEOUT - 1)) begin
                    tx_valid_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Host clear comes before CPU set so a set on the same index wins.
        if (host_wr && host_in) begin
            regs_d[host_sel]  = host_data;
            dirty_d[host_sel] = 1'b0;
        end
        if (cpu_wr && cpu_in) begin
            regs_d[cpu_wr_sel]  = cpu_wr_data;
            dirty_d[cpu_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            dirty_q    <= '0;
            wait_q     <= '0;
            rr_q       <= '0;
            state_q    <= ST_IDLE;
            tx_valid_q <= 1'b0;
            tx_sel_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            dirty_q    <= dirty_d;
            wait_q     <= wait_d;
            rr_q       <= rr_d;
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_sel_q   <= tx_sel_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef IO_SCHED_WATCHDOG_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_timeout = timeout_q;
`else
    // Without the watchdog a frame waits indefinitely; TX_TIMEOUT is kept so both builds share a parameter list.
    assign tx_timeout = 1'b0 && (TX_TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_io_reg_scheduler.sv
// Directed bench for io_reg_scheduler: a per-cycle vector table plus hand-written sequences
// for starvation, hold/rewrite, collision, watchdog and reset during SEND.
module tb_io_reg_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  cpu_rd_sel = '0;
    logic [14:0] cpu_rd_data;
    logic        cpu_we = 1'b0;
    logic [4:0]  cpu_wr_sel = '0;
    logic [14:0] cpu_wr_data = '0;
    logic        cpu_stall;
    logic        host_valid = 1'b0;
    logic [4:0]  host_sel = '0;
    logic [14:0] host_data = '0;
    logic        host_ready;
    logic        tx_valid;
    logic [4:0]  tx_sel;
    logic [14:0] tx_data;
    logic        tx_ready = 1'b0;
    logic [14:0] verb_data;
    logic        tx_timeout;

    io_reg_scheduler #(.NUM_REGS(16), .MAX_WAIT(7), .TX_TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_rd_sel(cpu_rd_sel), .cpu_rd_data(cpu_rd_data),
        .cpu_we(cpu_we), .cpu_wr_sel(cpu_wr_sel), .cpu_wr_data(cpu_wr_data), .cpu_stall(cpu_stall),
        .host_valid(host_valid), .host_sel(host_sel), .host_data(host_data), .host_ready(host_ready),
        .tx_valid(tx_valid), .tx_sel(tx_sel), .tx_data(tx_data), .tx_ready(tx_ready),
        .verb_data(verb_data), .tx_timeout(tx_timeout)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wsel;
        logic [14:0] wdata;
        logic        hv;
        logic [4:0]  hsel;
        logic [14:0] hdata;
        logic        trdy;
        logic [4:0]  rsel;
        logic        e_hr;
        logic        e_stall;
        logic        e_tv;
        logic [4:0]  e_tsel;
        logic [14:0] e_tdata;
        logic [14:0] e_rd;
        logic [14:0] e_verb;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic we, input logic [4:0] wsel, input logic [14:0] wdata,
                                input logic hv, input logic [4:0] hsel, input logic [14:0] hdata,
                                input logic trdy, input logic [4:0] rsel,
                                input logic e_hr, input logic e_stall, input logic e_tv,
                                input logic [4:0] e_tsel, input logic [14:0] e_tdata,
                                input logic [14:0] e_rd, input logic [14:0] e_verb);
        vec_t v;
        v.we = we; v.wsel = wsel; v.wdata = wdata;
        v.hv = hv; v.hsel = hsel; v.hdata = hdata;
        v.trdy = trdy; v.rsel = rsel;
        v.e_hr = e_hr; v.e_stall = e_stall; v.e_tv = e_tv;
        v.e_tsel = e_tsel; v.e_tdata = e_tdata; v.e_rd = e_rd; v.e_verb = e_verb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic quiet();
        cpu_we = 1'b0;
        host_valid = 1'b0;
    endtask

    task automatic wait_tv(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!tx_valid && n < max_cyc) begin
            tick();
            #1;
            n++;
        end
        check({name, "_tv_seen"}, 32'(tx_valid), 32'd1);
    endtask

    int  cnt;
    logic seen;

    initial begin
        // Frame 0 is held (tx_ready=0) while reg3 and reg1 get dirty, so after it completes
        // rr_ptr=1 and the scheduler sends (1,2222) before (3,1111).
        tbl[0]  = mk(1, 0, 15'h0100, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,        15'h0000, 15'h0000);
        tbl[1]  = mk(1, 3, 15'h1111, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,        15'h0100, 15'h0100);
        tbl[2]  = mk(1, 1, 15'h2222, 0, 0, 0, 0, 3,  0, 0, 1, 0, 15'h0100, 15'h1111, 15'h0100);
        tbl[3]  = mk(0, 0, 0,        0, 0, 0, 1, 1,  1, 0, 1, 0, 15'h0100, 15'h2222, 15'h0100);
        tbl[4]  = mk(0, 0, 0,        0, 0, 0, 1, 0,  1, 0, 0, 0, 0,        15'h0100, 15'h0100);
        tbl[5]  = mk(0, 0, 0,        0, 0, 0, 1, 1,  1, 0, 1, 1, 15'h2222, 15'h2222, 15'h0100);
        tbl[6]  = mk(0, 0, 0,        0, 0, 0, 1, 3,  1, 0, 0, 0, 0,        15'h1111, 15'h0100);
        tbl[7]  = mk(0, 0, 0,        0, 0, 0, 0, 3,  1, 0, 1, 3, 15'h1111, 15'h1111, 15'h0100);
        tbl[8]  = mk(0, 0, 0,        0, 0, 0, 0, 3,  1, 0, 1, 3, 15'h1111, 15'h1111, 15'h0100);
        tbl[9]  = mk(0, 0, 0,        0, 0, 0, 1, 3,  1, 0, 1, 3, 15'h1111, 15'h1111, 15'h0100);
        tbl[10] = mk(0, 0, 0,        1, 2, 15'h0abc, 0, 2,  1, 0, 0, 0, 0, 15'h0000, 15'h0100);
        tbl[11] = mk(0, 0, 0,        0, 0, 0, 0, 2,  1, 0, 0, 0, 0,        15'h0abc, 15'h0100);
        tbl[12] = mk(0, 0, 0,        1, 31, 15'h7fff, 0, 31, 1, 0, 0, 0, 0, 15'h0000, 15'h0100);
        tbl[13] = mk(0, 0, 0,        0, 0, 0, 0, 15, 1, 0, 0, 0, 0,        15'h0000, 15'h0100);
        tbl[14] = mk(0, 0, 0,        0, 0, 0, 0, 0,  1, 0, 0, 0, 0,        15'h0100, 15'h0100);

        // Reset state
        cpu_rd_sel = 5'd5;
        repeat (2) tick();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_sel", 32'(tx_sel), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check("rst_verb", 32'(verb_data), 32'd0);
        check("rst_rd5", 32'(cpu_rd_data), 32'd0);
        reset_n = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            tick();
            cpu_we = tbl[i].we; cpu_wr_sel = tbl[i].wsel; cpu_wr_data = tbl[i].wdata;
            host_valid = tbl[i].hv; host_sel = tbl[i].hsel; host_data = tbl[i].hdata;
            tx_ready = tbl[i].trdy; cpu_rd_sel = tbl[i].rsel;
            #1;
            check($sformatf("v%0d_host_ready", i), 32'(host_ready), 32'(tbl[i].e_hr));
            check($sformatf("v%0d_cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
            check($sformatf("v%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].e_tv));
            if (tbl[i].e_tv) begin
                check($sformatf("v%0d_tx_sel", i), 32'(tx_sel), 32'(tbl[i].e_tsel));
                check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].e_tdata));
            end
            check($sformatf("v%0d_rd_data", i), 32'(cpu_rd_data), 32'(tbl[i].e_rd));
            check($sformatf("v%0d_verb", i), 32'(verb_data), 32'(tbl[i].e_verb));
        end

        // Starvation: CPU writes every cycle, host waits 7 cycles then preempts
        for (int k = 1; k <= 8; k++) begin
            tick();
            cpu_we = 1'b1; cpu_wr_sel = 5'd5; cpu_wr_data = 15'h0055;
            host_valid = 1'b1; host_sel = 5'd0; host_data = 15'h0025;
            tx_ready = 1'b1;
            #1;
            check($sformatf("starve%0d_host_ready", k), 32'(host_ready), (k < 8) ? 32'd0 : 32'd1);
            check($sformatf("starve%0d_cpu_stall", k), 32'(cpu_stall), (k < 8) ? 32'd0 : 32'd1);
        end
        tick();
        quiet();
        #1;
        check("starve_verb", 32'(verb_data), 32'h0025);
        check("starve_released_stall", 32'(cpu_stall), 32'd0);
        repeat (6) tick();
        cpu_rd_sel = 5'd5;
        #1;
        check("starve_rd5", 32'(cpu_rd_data), 32'h0055);
        check("starve_drained", 32'(tx_valid), 32'd0);

        // Hold/rewrite: reg4 in SEND, CPU rewrites it, frame stays, then resent
        tick();
        cpu_we = 1'b1; cpu_wr_sel = 5'd4; cpu_wr_data = 15'h0444; tx_ready = 1'b0;
        tick();
        quiet();
        #1;
        check("lat_tv_n1", 32'(tx_valid), 32'd0);
        tick();
        #1;
        check("lat_tv_n2", 32'(tx_valid), 32'd1);
        check("hold_sel", 32'(tx_sel), 32'd4);
        check("hold_data0", 32'(tx_data), 32'h0444);
        tick();
        cpu_we = 1'b1; cpu_wr_data = 15'h0777;
        #1;
        check("hold_data1", 32'(tx_data), 32'h0444);
        tick();
        quiet();
        cpu_rd_sel = 5'd4;
        #1;
        check("hold_data2", 32'(tx_data), 32'h0444);
        check("hold_rd4", 32'(cpu_rd_data), 32'h0777);
        tick();
        tx_ready = 1'b1;
        #1;
        check("hold_tv_before_ready", 32'(tx_valid), 32'd1);
        check("hold_data3", 32'(tx_data), 32'h0444);
        tick();
        #1;
        check("hold_idle_gap", 32'(tx_valid), 32'd0);
        tick();
        #1;
        check("resend_tv", 32'(tx_valid), 32'd1);
        check("resend_sel", 32'(tx_sel), 32'd4);
        check("resend_data", 32'(tx_data), 32'h0777);
        tick();
        #1;
        check("resend_done", 32'(tx_valid), 32'd0);

        // Collision on reg2: CPU not starved, wins; dirty[2] set -> frame goes out
        tick();
        cpu_we = 1'b1; cpu_wr_sel = 5'd2; cpu_wr_data = 15'h0222;
        host_valid = 1'b1; host_sel = 5'd2; host_data = 15'h0333;
        #1;
        check("coll_host_ready", 32'(host_ready), 32'd0);
        check("coll_cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        quiet();
        cpu_rd_sel = 5'd2;
        #1;
        check("coll_rd2", 32'(cpu_rd_data), 32'h0222);
        tick();
        #1;
        check("coll_tv", 32'(tx_valid), 32'd1);
        check("coll_sel", 32'(tx_sel), 32'd2);
        check("coll_data", 32'(tx_data), 32'h0222);
        tick();
        #1;
        check("coll_done", 32'(tx_valid), 32'd0);

        // Watchdog
        tick();
        cpu_we = 1'b1; cpu_wr_sel = 5'd6; cpu_wr_data = 15'h0666; tx_ready = 1'b0;
        tick();
        quiet();
        #1;
        wait_tv(4, "wd");
`ifdef IO_SCHED_WATCHDOG_EN
        check("wd_no_early_pulse", 32'(tx_timeout), 32'd0);
        cnt = 1;
        while (cnt < 20) begin
            tick();
            #1;
            if (!tx_valid) break;
            cnt++;
        end
        check("wd_send_cycles", 32'(cnt), 32'd8);
        check("wd_pulse", 32'(tx_timeout), 32'd1);
        check("wd_tv_dropped", 32'(tx_valid), 32'd0);
        tick();
        #1;
        check("wd_pulse_one_cycle", 32'(tx_timeout), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            #1;
            seen = seen | tx_valid;
        end
        check("wd_dropped_clean", 32'(seen), 32'd0);
`else
        seen = 1'b0;
        repeat (12) begin
            tick();
            #1;
            seen = seen | tx_timeout;
        end
        check("nowd_no_pulse", 32'(seen), 32'd0);
        check("nowd_still_send", 32'(tx_valid), 32'd1);
        check("nowd_sel", 32'(tx_sel), 32'd6);
        tick();
        tx_ready = 1'b1;
        tick();
        #1;
        check("nowd_done", 32'(tx_valid), 32'd0);
`endif

        // Reset during SEND: frame abandoned, pending dirty lost
        tick();
        cpu_we = 1'b1; cpu_wr_sel = 5'd7; cpu_wr_data = 15'h0707; tx_ready = 1'b0;
        tick();
        cpu_wr_sel = 5'd8; cpu_wr_data = 15'h0808;
        tick();
        quiet();
        #1;
        wait_tv(4, "mrst");
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cpu_rd_sel = 5'd7;
        #1;
        check("mrst_tv", 32'(tx_valid), 32'd0);
        check("mrst_tx_sel", 32'(tx_sel), 32'd0);
        check("mrst_tx_data", 32'(tx_data), 32'd0);
        check("mrst_rd7", 32'(cpu_rd_data), 32'd0);
        check("mrst_verb", 32'(verb_data), 32'd0);
        tx_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            #1;
            seen = seen | tx_valid;
        end
        check("mrst_dirty_lost", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1, "time limit");
    end

endmodule
